// File: rtl/alarm_bank.sv
// Bank of independent time-of-day alarm channels with ring timeout,
// bounded snooze and global dismiss.
module alarm_bank #(
    parameter int N_ALARMS   = 4,
    parameter int RING_MIN   = 5,
    parameter int SNOOZE_MIN = 9,
    parameter int MAX_SNOOZE = 3,
    localparam int IW = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                min_tick,
    input  logic [6:0]          tmin,
    input  logic [6:0]          thrs,
    input  logic [6:0]          tday,
    input  logic                cfg_we,
    input  logic [IW-1:0]       cfg_idx,
    input  logic [6:0]          cfg_min,
    input  logic [6:0]          cfg_hrs,
    input  logic [6:0]          cfg_daymask,
    input  logic                cfg_en,
    input  logic                snooze,
    input  logic                dismiss,
    output logic                buzz,
    output logic [N_ALARMS-1:0] ring_vec,
    output logic [N_ALARMS-1:0] snooze_vec
);

    localparam int CMAX = (RING_MIN > SNOOZE_MIN) ? RING_MIN : SNOOZE_MIN;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int SW   = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RINGING,
        SNOOZED
    } state_t;

    state_t        state_q [N_ALARMS];
    state_t        state_d [N_ALARMS];
    logic [CW-1:0] cnt_q   [N_ALARMS];
    logic [CW-1:0] cnt_d   [N_ALARMS];
    logic [SW-1:0] snz_q   [N_ALARMS];
    logic [SW-1:0] snz_d   [N_ALARMS];

    logic [6:0]    min_q   [N_ALARMS];
    logic [6:0]    hrs_q   [N_ALARMS];
    logic [6:0]    mask_q  [N_ALARMS];
    logic [N_ALARMS-1:0] en_q;

    logic [N_ALARMS-1:0] hit;
    logic [N_ALARMS-1:0] trig;
    logic                day_ok;

    assign day_ok = (tday < 7'd7);

    // Out-of-range cfg_idx matches no channel, so it is ignored.
    always_comb begin
        hit  = '0;
        trig = '0;
        for (int i = 0; i < N_ALARMS; i++) begin
            hit[i]  = cfg_we && (cfg_idx == IW'(i));
            trig[i] = min_tick && en_q[i] && day_ok
                   && (tmin == min_q[i]) && (thrs == hrs_q[i])
                   && mask_q[i][tday[2:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q <= '0;
            for (int i = 0; i < N_ALARMS; i++) begin
                min_q[i]  <= '0;
                hrs_q[i]  <= '0;
                mask_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_ALARMS; i++) begin
                if (hit[i]) begin
                    min_q[i]  <= cfg_min;
                    hrs_q[i]  <= cfg_hrs;
                    mask_q[i] <= cfg_daymask;
                    en_q[i]   <= cfg_en;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ALARMS; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
                snz_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < N_ALARMS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                snz_q[i]   <= snz_d[i];
            end
        end
    end

    // Priority per channel: config write, dismiss, snooze, minute tick.
    always_comb begin
        for (int i = 0; i < N_ALARMS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            snz_d[i]   = snz_q[i];
            if (hit[i]) begin
                state_d[i] = IDLE;
                cnt_d[i]   = '0;
                snz_d[i]   = '0;
            end else begin
                unique case (state_q[i])
                    IDLE: begin
                        if (trig[i]) begin
                            state_d[i] = RINGING;
                            cnt_d[i]   = CW'(RING_MIN);
                            snz_d[i]   = '0;
                        end
                    end
                    RINGING: begin
                        if (dismiss) begin
                            state_d[i] = IDLE;
                            cnt_d[i]   = '0;
                            snz_d[i]   = '0;
                        end else if (snooze && snz_q[i] < SW'(MAX_SNOOZE)) begin
                            state_d[i] = SNOOZED;
                            cnt_d[i]   = CW'(SNOOZE_MIN);
                            snz_d[i]   = snz_q[i] + SW'(1);
                        end else if (min_tick) begin
                            if (cnt_q[i] <= CW'(1)) begin
                                state_d[i] = IDLE;
                                cnt_d[i]   = '0;
                                snz_d[i]   = '0;
                            end else begin
                                cnt_d[i] = cnt_q[i] - CW'(1);
                            end
                        end
                    end
                    SNOOZED: begin
                        if (dismiss) begin
                            state_d[i] = IDLE;
                            cnt_d[i]   = '0;
                            snz_d[i]   = '0;
                        end else if (min_tick) begin
                            if (cnt_q[i] <= CW'(1)) begin
                                state_d[i] = RINGING;
                                cnt_d[i]   = CW'(RING_MIN);
                            end else begin
                                cnt_d[i] = cnt_q[i] - CW'(1);
                            end
                        end
                    end
                    default: begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                        snz_d[i]   = '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        ring_vec   = '0;
        snooze_vec = '0;
        for (int i = 0; i < N_ALARMS; i++) begin
            ring_vec[i]   = (state_q[i] == RINGING);
            snooze_vec[i] = (state_q[i] == SNOOZED);
        end
    end

    assign buzz = |ring_vec;

endmodule

// File: tb/tb_alarm_bank.sv
// Scoreboard bench for alarm_bank: directed scenarios then random
// traffic against a minutes-remaining reference model.
module tb_alarm_bank;

    localparam int N  = 4;
    localparam int RM = 5;
    localparam int SM = 9;
    localparam int MS = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         min_tick = 1'b0;
    logic [6:0]   tmin = '0, thrs = '0, tday = '0;
    logic         cfg_we = 1'b0;
    logic [1:0]   cfg_idx = '0;
    logic [6:0]   cfg_min = '0, cfg_hrs = '0, cfg_daymask = '0;
    logic         cfg_en = 1'b0;
    logic         snooze = 1'b0, dismiss = 1'b0;
    logic         buzz;
    logic [N-1:0] ring_vec, snooze_vec;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alarm_bank #(
        .N_ALARMS(N), .RING_MIN(RM), .SNOOZE_MIN(SM), .MAX_SNOOZE(MS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .min_tick(min_tick),
        .tmin(tmin), .thrs(thrs), .tday(tday),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_min(cfg_min),
        .cfg_hrs(cfg_hrs), .cfg_daymask(cfg_daymask), .cfg_en(cfg_en),
        .snooze(snooze), .dismiss(dismiss),
        .buzz(buzz), .ring_vec(ring_vec), .snooze_vec(snooze_vec)
    );

    typedef struct {
        logic       tick;
        int         tm, th, td;
        logic       snz, dis, we;
        int         idx, cmin, chrs;
        logic [6:0] cmask;
        logic       cen;
    } stim_t;

    // Reference model: a channel rings while ring_left>0 and is
    // snoozed while snz_left>0.
    int         m_min [N], m_hrs [N];
    logic [6:0] m_mask [N];
    logic       m_en [N];
    int         ring_left [N], snz_left [N], used [N];

    logic [2*N:0] expq [$];

    task automatic check(input string name, input logic [2*N:0] act,
                         input logic [2*N:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got buzz/snz/ring=%b want %b",
                     name, $time, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_min[i] = 0; m_hrs[i] = 0; m_mask[i] = '0; m_en[i] = 0;
            ring_left[i] = 0; snz_left[i] = 0; used[i] = 0;
        end
    endfunction

    function automatic logic [2*N:0] model_out();
        logic [N-1:0] r, z;
        r = '0; z = '0;
        for (int i = 0; i < N; i++) begin
            r[i] = ring_left[i] > 0;
            z[i] = snz_left[i] > 0;
        end
        return {|r, z, r};
    endfunction

    function automatic void model_step(input stim_t s);
        for (int i = 0; i < N; i++) begin
            if (s.we && s.idx == i) begin
                m_min[i] = s.cmin; m_hrs[i] = s.chrs;
                m_mask[i] = s.cmask; m_en[i] = s.cen;
                ring_left[i] = 0; snz_left[i] = 0; used[i] = 0;
            end else if (ring_left[i] > 0) begin
                if (s.dis) begin
                    ring_left[i] = 0; used[i] = 0;
                end else if (s.snz && used[i] < MS) begin
                    ring_left[i] = 0; snz_left[i] = SM; used[i]++;
                end else if (s.tick) begin
                    ring_left[i]--;
                    if (ring_left[i] == 0) used[i] = 0;
                end
            end else if (snz_left[i] > 0) begin
                if (s.dis) begin
                    snz_left[i] = 0; used[i] = 0;
                end else if (s.tick) begin
                    snz_left[i]--;
                    if (snz_left[i] == 0) ring_left[i] = RM;
                end
            end else if (s.tick && m_en[i] && s.tm == m_min[i]
                         && s.th == m_hrs[i] && s.td < 7) begin
                if (m_mask[i][s.td]) begin
                    ring_left[i] = RM; used[i] = 0;
                end
            end
        end
    endfunction

    function automatic stim_t nop();
        stim_t s;
        s.tick = 0; s.tm = 59; s.th = 23; s.td = 6;
        s.snz = 0; s.dis = 0; s.we = 0; s.idx = 0;
        s.cmin = 0; s.chrs = 0; s.cmask = '0; s.cen = 0;
        return s;
    endfunction

    function automatic stim_t tk(input int h, input int m, input int d);
        stim_t s;
        s = nop();
        s.tick = 1; s.th = h; s.tm = m; s.td = d;
        return s;
    endfunction

    function automatic stim_t cf(input int idx, input int h, input int m,
                                 input logic [6:0] mask, input logic en);
        stim_t s;
        s = nop();
        s.we = 1; s.idx = idx; s.chrs = h; s.cmin = m;
        s.cmask = mask; s.cen = en;
        return s;
    endfunction

    function automatic stim_t us(input logic snz, input logic dis);
        stim_t s;
        s = nop();
        s.snz = snz; s.dis = dis;
        return s;
    endfunction

    task automatic step(input stim_t s);
        @(negedge clk);
        min_tick    = s.tick;
        tmin        = 7'(s.tm);
        thrs        = 7'(s.th);
        tday        = 7'(s.td);
        snooze      = s.snz;
        dismiss     = s.dis;
        cfg_we      = s.we;
        cfg_idx     = 2'(s.idx);
        cfg_min     = 7'(s.cmin);
        cfg_hrs     = 7'(s.chrs);
        cfg_daymask = s.cmask;
        cfg_en      = s.cen;
        model_step(s);
        expq.push_back(model_out());
    endtask

    initial begin : monitor
        logic [2*N:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                check("outputs", {buzz, snooze_vec, ring_vec}, e);
            end
        end
    end

    initial begin : driver
        stim_t s;
        model_reset();
        #3;
        check("reset_state", {buzz, snooze_vec, ring_vec}, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single channel ring and timeout
        step(cf(0, 7, 30, 7'h7F, 1));
        step(tk(7, 30, 2));
        for (int k = 0; k < RM; k++) step(tk(7, 31 + k, 2));
        step(nop());

        // Day mask gating
        step(cf(1, 8, 0, 7'b0000001, 1));
        step(tk(8, 0, 3));
        step(tk(8, 0, 0));
        step(us(0, 1));

        // Snooze cycling up to the limit
        step(tk(7, 30, 2));
        for (int r = 0; r < MS; r++) begin
            step(us(1, 0));
            for (int k = 0; k < SM; k++) step(tk(7, 40, 2));
        end
        step(us(1, 0));
        step(nop());
        step(us(0, 1));

        // Two channels, snooze and dismiss together
        step(cf(0, 6, 0, 7'h7F, 1));
        step(cf(2, 6, 0, 7'h7F, 1));
        step(tk(6, 0, 1));
        step(us(1, 1));

        // Disable while ringing
        step(cf(3, 6, 0, 7'h7F, 1));
        step(tk(6, 0, 1));
        step(cf(3, 6, 0, 7'h7F, 0));
        step(us(0, 1));
        step(tk(6, 0, 1));
        step(us(0, 1));

        // Reset during snooze
        step(tk(6, 0, 4));
        step(us(1, 0));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        min_tick = 0; snooze = 0; dismiss = 0; cfg_we = 0;
        #1;
        check("async_reset", {buzz, snooze_vec, ring_vec}, '0);
        model_reset();
        #1;
        rst_n = 1'b1;
        step(tk(6, 0, 4));
        step(tk(6, 0, 4));

        // Random traffic
        for (int i = 0; i < N; i++)
            step(cf(i, 6 + $urandom_range(1), 30 * $urandom_range(1),
                    7'($urandom), 1));
        for (int c = 0; c < 3000; c++) begin
            s = nop();
            if ($urandom_range(2) == 0) begin
                s.tick = 1;
                s.th = 6 + $urandom_range(1);
                s.tm = 30 * $urandom_range(1);
                s.td = $urandom_range(7);
            end
            s.snz = ($urandom_range(7) == 0);
            s.dis = ($urandom_range(39) == 0);
            if ($urandom_range(49) == 0) begin
                s.we = 1;
                s.idx = $urandom_range(N - 1);
                s.chrs = 6 + $urandom_range(1);
                s.cmin = 30 * $urandom_range(1);
                s.cmask = 7'($urandom);
                s.cen = ($urandom_range(3) != 0);
            end
            step(s);
        end

        for (int w = 0; w < 20 && expq.size() > 0; w++) @(posedge clk);
        #2;
        if (expq.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d pending, want 0", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
